// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - self-synchronising PRBS31 (x^31 + x^28 + 1) serial checker
// Seeds a local LFSR from the stream, verifies, locks, then counts errors with windowed loss-of-lock.
module prbs31_checker #(
    parameter int LOCK_COUNT  = 32,
    parameter int WINDOW      = 64,
    parameter int LOSS_THRESH = 8,
    parameter int ERR_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    input  logic                 clear,
    output logic                 locked,
    output logic                 err_flag,
    output logic [ERR_WIDTH-1:0] err_count
);

    localparam int MC_W = (LOCK_COUNT  > 1) ? $clog2(LOCK_COUNT)    : 1;
    localparam int WB_W = (WINDOW      > 1) ? $clog2(WINDOW)        : 1;
    localparam int WE_W = $clog2(LOSS_THRESH + 1);

    localparam logic [MC_W-1:0]      MATCH_LAST = MC_W'(LOCK_COUNT - 1);
    localparam logic [WB_W-1:0]      WIN_LAST   = WB_W'(WINDOW - 1);
    localparam logic [WE_W-1:0]      LOSS_LAST  = WE_W'(LOSS_THRESH - 1);
    localparam logic [ERR_WIDTH-1:0] ERR_MAX    = '1;

    typedef enum logic [1:0] {
        SEED,
        VERIFY,
        LOCKED
    } state_t;

    state_t          state;
    logic [30:0]     sr;
    logic [4:0]      seed_cnt;
    logic [MC_W-1:0] match_cnt;
    logic [WB_W-1:0] win_bits;
    logic [WE_W-1:0] win_err;
    logic            pred;
    logic            miss;

    assign pred = sr[27] ^ sr[30];
    assign miss = bit_in ^ pred;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= SEED;
            sr        <= '0;
            seed_cnt  <= '0;
            match_cnt <= '0;
            win_bits  <= '0;
            win_err   <= '0;
            locked    <= 1'b0;
            err_flag  <= 1'b0;
            err_count <= '0;
        end else begin
            err_flag <= 1'b0;
            if (clear) begin
                err_count <= '0;
            end
            if (bit_valid) begin
                case (state)
                    SEED: begin
                        sr <= {sr[29:0], bit_in};
                        if (seed_cnt == 5'd30) begin
                            seed_cnt  <= '0;
                            match_cnt <= '0;
                            state     <= VERIFY;
                        end else begin
                            seed_cnt <= seed_cnt + 5'd1;
                        end
                    end
                    VERIFY: begin
                        sr <= {sr[29:0], bit_in};
                        // An all-zero register predicts zeros forever, so it never counts as a match.
                        if (!miss && (sr != '0)) begin
                            if (match_cnt == MATCH_LAST) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                win_bits <= '0;
                                win_err  <= '0;
                            end else begin
                                match_cnt <= match_cnt + 1'b1;
                            end
                        end else begin
                            state    <= SEED;
                            seed_cnt <= '0;
                        end
                    end
                    LOCKED: begin
                        // Free-run on the prediction so a corrupted input bit never poisons the LFSR.
                        sr <= {sr[29:0], pred};
                        if (miss) begin
                            err_flag <= 1'b1;
                            if (!clear && (err_count != ERR_MAX)) begin
                                err_count <= err_count + 1'b1;
                            end
                        end
                        if (miss && (win_err == LOSS_LAST)) begin
                            state    <= SEED;
                            locked   <= 1'b0;
                            seed_cnt <= '0;
                            win_bits <= '0;
                            win_err  <= '0;
                        end else if (win_bits == WIN_LAST) begin
                            win_bits <= '0;
                            win_err  <= '0;
                        end else begin
                            win_bits <= win_bits + 1'b1;
                            win_err  <= win_err + {{(WE_W-1){1'b0}}, miss};
                        end
                    end
                    default: begin
                        state <= SEED;
                    end
                endcase
            end
        end
    end

endmodule
